// File: rtl/carus_sram_pkg.sv
// Shared types and helpers for the banked Carus SRAM.
// Retention state encoding and wake counter sizing.
package carus_sram_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      RET    = 2'd1,
      WAKE   = 2'd2
   } carus_sram_state_e;

   // Counter must hold wakeup_cycles-1; never narrower than one bit.
   function automatic int unsigned wake_cnt_width(input int unsigned wakeup_cycles);
      if (wakeup_cycles > 1) begin
         return $clog2(wakeup_cycles);
      end
      return 1;
   endfunction

endpackage

// File: rtl/carus_sram_bank.sv
// Single-port, byte-writable RAM bank with enable and registered read output.
// Inferred as block RAM; contents are never reset.
module carus_sram_bank #(
   parameter int unsigned NUM_WORDS  = 1024,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned BeWidth   = DATA_WIDTH / 8,
   localparam int unsigned AddrWidth = $clog2(NUM_WORDS)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [AddrWidth-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [BeWidth-1:0]    be,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   // The read register only updates on reads, so it holds its word while the bank is idle.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int unsigned k = 0; k < BeWidth; k++) begin
               if (be[k]) begin
                  mem[addr][8*k +: 8] <= wdata[8*k +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/carus_sram_banked.sv
// Multi-bank SRAM with one req/gnt port and per-bank retention FSMs.
// CARUS_SRAM_OUT_REG_EN adds an output register after the bank mux (read latency 2).
module carus_sram_banked
   import carus_sram_pkg::*;
#(
   parameter int unsigned NUM_WORDS     = 1024,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned NUM_BANKS     = 4,
   parameter int unsigned WAKEUP_CYCLES = 4,
   localparam int unsigned BeWidth       = DATA_WIDTH / 8,
   localparam int unsigned BankAddrWidth = $clog2(NUM_WORDS),
   localparam int unsigned BankSelWidth  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int unsigned AddrWidth     = BankAddrWidth + $clog2(NUM_BANKS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic                  we_i,
   input  logic [AddrWidth-1:0]  addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BeWidth-1:0]    be_i,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   input  logic [NUM_BANKS-1:0]  ret_req_i,
   output logic [NUM_BANKS-1:0]  ret_ack_o
);

   localparam int unsigned CntWidth = wake_cnt_width(WAKEUP_CYCLES);
   localparam logic [CntWidth-1:0] WakeLoad = CntWidth'(WAKEUP_CYCLES - 1);

   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_data_width
      $error("DATA_WIDTH must be a non-zero multiple of 8");
   end
   if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_num_words
      $error("NUM_WORDS must be a power of two >= 2");
   end
   if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_num_banks
      $error("NUM_BANKS must be a power of two >= 1");
   end
   if (WAKEUP_CYCLES < 1) begin : g_bad_wakeup
      $error("WAKEUP_CYCLES must be >= 1");
   end

   logic [BankSelWidth-1:0]  bank_sel;
   logic [BankSelWidth-1:0]  sel_q;
   logic [BankAddrWidth-1:0] bank_addr;
   logic                     target_active;
   logic                     gnt;
   logic                     rvalid_q;
   logic [NUM_BANKS-1:0]     bank_en;
   logic [DATA_WIDTH-1:0]    bank_rdata [NUM_BANKS];
   logic [DATA_WIDTH-1:0]    mux_rdata;

   carus_sram_state_e        state_q [NUM_BANKS];
   carus_sram_state_e        state_d [NUM_BANKS];
   logic [CntWidth-1:0]      cnt_q   [NUM_BANKS];
   logic [CntWidth-1:0]      cnt_d   [NUM_BANKS];

   assign bank_addr = addr_i[BankAddrWidth-1:0];

   if (NUM_BANKS > 1) begin : g_multi_bank
      assign bank_sel = addr_i[AddrWidth-1:BankAddrWidth];
   end else begin : g_single_bank
      assign bank_sel = '0;
   end

   // Grant and per-bank enables; only an ACTIVE bank may be accessed.
   always_comb begin
      target_active = 1'b0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (bank_sel == BankSelWidth'(b)) begin
            target_active = (state_q[b] == ACTIVE);
         end
      end
      gnt = req_i & target_active;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         bank_en[b] = gnt & (bank_sel == BankSelWidth'(b));
      end
   end

   assign gnt_o = gnt;

   // Retention FSMs: a granted access defers RET entry by a cycle.
   always_comb begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         state_d[b]   = state_q[b];
         cnt_d[b]     = cnt_q[b];
         ret_ack_o[b] = (state_q[b] == RET);
         case (state_q[b])
            ACTIVE: begin
               if (ret_req_i[b] && !bank_en[b]) begin
                  state_d[b] = RET;
               end
            end
            RET: begin
               if (!ret_req_i[b]) begin
                  state_d[b] = WAKE;
                  cnt_d[b]   = WakeLoad;
               end
            end
            WAKE: begin
               if (cnt_q[b] == '0) begin
                  state_d[b] = ACTIVE;
               end else begin
                  cnt_d[b] = cnt_q[b] - 1'b1;
               end
            end
            default: begin
               state_d[b] = ACTIVE;
               cnt_d[b]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= ACTIVE;
            cnt_q[b]   <= '0;
         end
         rvalid_q <= 1'b0;
         sel_q    <= '0;
      end else begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= state_d[b];
            cnt_q[b]   <= cnt_d[b];
         end
         rvalid_q <= gnt & ~we_i;
         if (gnt && !we_i) begin
            sel_q <= bank_sel;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      carus_sram_bank #(
         .NUM_WORDS  (NUM_WORDS),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .clk   (clk_i),
         .en    (bank_en[b]),
         .we    (we_i),
         .addr  (bank_addr),
         .wdata (wdata_i),
         .be    (be_i),
         .rdata (bank_rdata[b])
      );
   end

   always_comb begin
      mux_rdata = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (sel_q == BankSelWidth'(b)) begin
            mux_rdata = bank_rdata[b];
         end
      end
   end

`ifdef CARUS_SRAM_OUT_REG_EN
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= rvalid_q;
         out_data_q  <= rvalid_q ? mux_rdata : '0;
      end
   end

   assign rvalid_o = out_valid_q;
   assign rdata_o  = out_data_q;
`else
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rvalid_q ? mux_rdata : '0;
`endif

endmodule

// File: tb/tb_carus_sram_banked.sv
// Directed self-checking bench for carus_sram_banked (4 banks x 1024 words x 32 bits).
module tb_carus_sram_banked;

`ifdef CARUS_SRAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req;
   logic        gnt;
   logic        we;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        rvalid;
   logic [31:0] rdata;
   logic [3:0]  ret_req;
   logic [3:0]  ret_ack;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   carus_sram_banked #(
      .NUM_WORDS     (1024),
      .DATA_WIDTH    (32),
      .NUM_BANKS     (4),
      .WAKEUP_CYCLES (4)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .gnt_o     (gnt),
      .we_i      (we),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .be_i      (be),
      .rvalid_o  (rvalid),
      .rdata_o   (rdata),
      .ret_req_i (ret_req),
      .ret_ack_o (ret_ack)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      be    = '0;
   endtask

   task automatic write_word(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
      int n = 0;
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
      #1;
      while (gnt !== 1'b1 && n < 40) begin
         cyc();
         n++;
      end
      n_checks++;
      if (n != 0) begin
         n_fail++;
         $display("FAIL write_grant addr=%h: waited %0d cycles, required 0", a, n);
      end
      cyc();
      idle();
   endtask

   task automatic read_word(input logic [11:0] a, input logic [31:0] exp, output int waited);
      int          n = 0;
      logic        v [3];
      logic [31:0] d [3];
      req = 1'b1; we = 1'b0; addr = a; be = '0;
      #1;
      while (gnt !== 1'b1 && n < 40) begin
         cyc();
         n++;
      end
      waited = n;
      n_checks++;
      if (n >= 40) begin
         n_fail++;
         $display("FAIL read_grant_timeout addr=%h: no grant in %0d cycles", a, n);
      end
      cyc();
      idle();
      v[1] = rvalid; d[1] = rdata;
      cyc();
      v[2] = rvalid; d[2] = rdata;
      n_checks++;
      if (v[LAT] !== 1'b1) begin
         n_fail++;
         $display("FAIL read_rvalid addr=%h: got %b, required 1 at latency %0d", a, v[LAT], LAT);
      end
      n_checks++;
      if (d[LAT] !== exp) begin
         n_fail++;
         $display("FAIL read_data addr=%h: got %h, required %h", a, d[LAT], exp);
      end
      n_checks++;
      if (v[3-LAT] !== 1'b0) begin
         n_fail++;
         $display("FAIL read_single_pulse addr=%h: rvalid %b at cycle %0d, required 0",
                  a, v[3-LAT], 3 - LAT);
      end
   endtask

   task automatic test_reset();
      idle();
      ret_req = '0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b, required 0", gnt); end
      n_checks++;
      if (rvalid !== 1'b0) begin
         n_fail++; $display("FAIL reset_rvalid: got %b, required 0", rvalid);
      end
      n_checks++;
      if (rdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h, required 0", rdata);
      end
      n_checks++;
      if (ret_ack !== 4'h0) begin
         n_fail++; $display("FAIL reset_ret_ack: got %b, required 0000", ret_ack);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_write_read();
      int w;
      write_word(12'h000, 32'hDEADBEEF, 4'hF);
      write_word(12'hC05, 32'h12345678, 4'hF);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (rvalid !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL write_no_rvalid: rvalid=%b rdata=%h, required 0/0", rvalid, rdata);
         end
         cyc();
      end
      read_word(12'h000, 32'hDEADBEEF, w);
      read_word(12'hC05, 32'h12345678, w);
   endtask

   task automatic test_byte_enable();
      int w;
      write_word(12'h405, 32'hAABBCCDD, 4'hF);
      write_word(12'h405, 32'h11223344, 4'h5);
      read_word(12'h405, 32'hAA22CC44, w);
      write_word(12'h405, 32'hFFFFFFFF, 4'h0);
      read_word(12'h405, 32'hAA22CC44, w);
   endtask

   task automatic test_retention();
      int w;
      write_word(12'h410, 32'h55AA0001, 4'hF);
      write_word(12'h810, 32'h0BADF00D, 4'hF);
      ret_req[1] = 1'b1;
      #1;
      n_checks++;
      if (ret_ack !== 4'b0000) begin
         n_fail++; $display("FAIL ret_ack_before_edge: got %b, required 0000", ret_ack);
      end
      cyc();
      n_checks++;
      if (ret_ack !== 4'b0010) begin
         n_fail++; $display("FAIL ret_ack_entry: got %b, required 0010", ret_ack);
      end
      read_word(12'h810, 32'h0BADF00D, w);
      n_checks++;
      if (w != 0) begin
         n_fail++; $display("FAIL other_bank_grant: waited %0d, required 0", w);
      end
      req = 1'b1; we = 1'b0; addr = 12'h410;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (gnt !== 1'b0) begin
            n_fail++; $display("FAIL ret_stall_gnt: got %b, required 0", gnt);
         end
         cyc();
      end
      ret_req[1] = 1'b0;
      #1;
      n_checks++;
      if (ret_ack !== 4'b0010) begin
         n_fail++; $display("FAIL ret_ack_hold: got %b, required 0010", ret_ack);
      end
      cyc();
      n_checks++;
      if (ret_ack !== 4'b0000 || gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL wake_start: ret_ack=%b gnt=%b, required 0000/0", ret_ack, gnt);
      end
      read_word(12'h410, 32'h55AA0001, w);
      n_checks++;
      if (1 + w != 5) begin
         n_fail++; $display("FAIL wake_grant_latency: got %0d cycles, required 5", 1 + w);
      end
   endtask

   task automatic test_conflict();
      int          w;
      logic        v [3];
      logic [31:0] d [3];
      ret_req[0] = 1'b1;
      req = 1'b1; we = 1'b0; addr = 12'h000;
      #1;
      n_checks++;
      if (gnt !== 1'b1) begin
         n_fail++; $display("FAIL conflict_gnt: got %b, required 1", gnt);
      end
      cyc();
      idle();
      v[1] = rvalid; d[1] = rdata;
      n_checks++;
      if (ret_ack[0] !== 1'b0) begin
         n_fail++; $display("FAIL conflict_ack_deferred: got %b, required 0", ret_ack[0]);
      end
      cyc();
      v[2] = rvalid; d[2] = rdata;
      n_checks++;
      if (ret_ack[0] !== 1'b1) begin
         n_fail++; $display("FAIL conflict_ack_late: got %b, required 1", ret_ack[0]);
      end
      n_checks++;
      if (v[LAT] !== 1'b1 || d[LAT] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL conflict_read: rvalid=%b rdata=%h, required 1/deadbeef", v[LAT], d[LAT]);
      end
      ret_req[0] = 1'b0;
      repeat (6) cyc();
      read_word(12'h000, 32'hDEADBEEF, w);
      n_checks++;
      if (w != 0) begin
         n_fail++; $display("FAIL conflict_rewake: waited %0d, required 0", w);
      end
   endtask

   task automatic test_reset_mid_read();
      int w;
      ret_req[2] = 1'b1;
      cyc();
      n_checks++;
      if (ret_ack !== 4'b0100) begin
         n_fail++; $display("FAIL pre_reset_ack: got %b, required 0100", ret_ack);
      end
      req = 1'b1; we = 1'b0; addr = 12'hC05;
      #1;
      n_checks++;
      if (gnt !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_gnt: got %b, required 1", gnt);
      end
      cyc();
      idle();
      rst = 1'b1;
      #1;
      n_checks++;
      if (rvalid !== 1'b0 || rdata !== 32'h0 || ret_ack !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_read_reset: rvalid=%b rdata=%h ret_ack=%b, required 0/0/0000",
                  rvalid, rdata, ret_ack);
      end
      ret_req = '0;
      cyc();
      n_checks++;
      if (rvalid !== 1'b0 || rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_hold: rvalid=%b rdata=%h, required 0/0", rvalid, rdata);
      end
      rst = 1'b0;
      cyc();
      read_word(12'hC05, 32'h12345678, w);
      read_word(12'h405, 32'hAA22CC44, w);
      read_word(12'h000, 32'hDEADBEEF, w);
   endtask

   task automatic test_back_to_back();
      logic [11:0] addrs [8] = '{12'h001, 12'h402, 12'h803, 12'hC04,
                                 12'h005, 12'h406, 12'h807, 12'hC08};
      logic [31:0] datas [8] = '{32'hA0000001, 32'hB1000002, 32'hC2000003, 32'hD3000004,
                                 32'hE4000005, 32'hF5000006, 32'h06000007, 32'h17000008};
      logic        exp_v;
      logic [31:0] exp_d;
      for (int i = 0; i < 8; i++) begin
         req = 1'b1; we = 1'b1; addr = addrs[i]; wdata = datas[i]; be = 4'hF;
         #1;
         n_checks++;
         if (gnt !== 1'b1) begin
            n_fail++; $display("FAIL b2b_write_gnt[%0d]: got %b, required 1", i, gnt);
         end
         cyc();
      end
      idle();
      cyc();
      for (int t = 0; t < 12; t++) begin
         if (t < 8) begin
            req = 1'b1; we = 1'b0; addr = addrs[t];
         end else begin
            idle();
         end
         #1;
         if (t < 8) begin
            n_checks++;
            if (gnt !== 1'b1) begin
               n_fail++; $display("FAIL b2b_read_gnt[%0d]: got %b, required 1", t, gnt);
            end
         end
         exp_v = (t >= LAT) && (t < LAT + 8);
         exp_d = 32'h0;
         if (exp_v) exp_d = datas[t-LAT];
         n_checks++;
         if (rvalid !== exp_v || rdata !== exp_d) begin
            n_fail++;
            $display("FAIL b2b_read[%0d]: rvalid=%b rdata=%h, required %b/%h",
                     t, rvalid, rdata, exp_v, exp_d);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_retention();
      test_conflict();
      test_reset_mid_read();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
